mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU memory bus; the target end of the bus on which the CPU initiates MREAD/MWRITE.
- Decodes the I/O region (mem_addr[8] = 1) and serves it. RAM (0x000–0x0FF) is served elsewhere.
- Holds the LED output register, a synchronized switch input and a compare timer.
- Answers every request with a one-wait-state handshake (mem_ready), so the CPU FSM stalls in its memory state until acknowledged.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_timer.sv | 61 ++++++
 rtl/mmio_responder.sv | 111 +++++++++++
 tb/tb_mmio_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared encodings for the MMIO responder: bus commands, FSM states,
// timer register offsets and TSTAT bit positions.
package mmio_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  localparam logic [1:0] TCOUNT_OFF = 2'd0;
  localparam logic [1:0] TCMP_OFF   = 2'd1;
  localparam logic [1:0] TSTAT_OFF  = 2'd2;

  localparam int unsigned TSTAT_MATCH = 0;
  localparam int unsigned TSTAT_EN    = 1;

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: free-running TCOUNT, TCMP compare value, TSTAT {enable, sticky match}.
// Instantiated by mmio_responder only when MMIO_TIMER_EN is defined.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [1:0]  offset,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  logic [15:0] tcount;
  logic [15:0] tcmp;
  logic        en;
  logic        match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount <= '0;
      tcmp   <= '1;
      en     <= 1'b0;
      match  <= 1'b0;
    end else begin
      if (wr && offset == TCOUNT_OFF)
        tcount <= wdata;
      else if (en)
        tcount <= tcount + 16'd1;

      if (wr && offset == TCMP_OFF)
        tcmp <= wdata;

      if (wr && offset == TSTAT_OFF)
        en <= wdata[TSTAT_EN];

      // Set has priority over a same-cycle W1C
      if (en && tcount == tcmp)
        match <= 1'b1;
      else if (wr && offset == TSTAT_OFF && wdata[TSTAT_MATCH])
        match <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      TCOUNT_OFF: rdata = tcount;
      TCMP_OFF:   rdata = tcmp;
      TSTAT_OFF: begin
        rdata[TSTAT_MATCH] = match;
        rdata[TSTAT_EN]    = en;
      end
      default:    rdata = '0;
    endcase
  end

  assign irq = match;

endmodule

// File: rtl/mmio_responder.sv
// I/O-region target of the CPU memory bus: LED register, synchronized switches and
// (with MMIO_TIMER_EN defined) a compare timer; one-wait-state mem_ready handshake.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140,
  parameter logic [8:0] TMR_ADDR = 9'h180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  sw_in,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic        io_sel,
  output logic [7:0]  led_out,
  output logic        irq
);

  state_e      state;
  state_e      state_next;
  logic        accept;
  logic        is_read;
  logic        is_write;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [15:0] rd_mux;
  logic [15:0] tmr_rdata;
  logic        tmr_hit;

  assign is_read  = (mem_cmd == MREAD);
  assign is_write = (mem_cmd == MWRITE);
  assign io_sel   = (is_read || is_write) && mem_addr[8];
  assign tmr_hit  = (mem_addr[8:2] == TMR_ADDR[8:2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (io_sel) begin
        accept     = 1'b1;
        state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Derived straight from the state flop so a reset during ACK drops it at once
  assign mem_ready = (state == ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
      led_out   <= '0;
    end else if (accept) begin
      read_data <= is_read ? rd_mux : '0;
      if (is_write && mem_addr == LED_ADDR)
        led_out <= write_data[7:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (mem_addr == LED_ADDR)
      rd_mux = {8'b0, led_out};
    else if (mem_addr == SW_ADDR)
      rd_mux = {8'b0, sw_sync};
    else if (tmr_hit)
      rd_mux = tmr_rdata;
  end

`ifdef MMIO_TIMER_EN
  logic tmr_wr;
  assign tmr_wr = accept && is_write && tmr_hit;

  mmio_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .wr     (tmr_wr),
    .offset (mem_addr[1:0]),
    .wdata  (write_data),
    .rdata  (tmr_rdata),
    .irq    (irq)
  );
`else
  logic [7:0] unused_wdata_hi;
  assign unused_wdata_hi = write_data[15:8];
  assign tmr_rdata       = '0;
  assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with a per-cycle reference model of the register map.
module tb_mmio_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw_in;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        io_sel;
  logic [7:0]  led_out;
  logic        irq;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  mmio_responder #(
    .LED_ADDR (9'h100),
    .SW_ADDR  (9'h140),
    .TMR_ADDR (9'h180)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw_in      (sw_in),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .io_sel     (io_sel),
    .led_out    (led_out),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: register contents after the most recent clock edge
  logic [7:0]  m_led, m_sw1, m_sw2;
  logic [15:0] m_cnt, m_cmp, m_rdata;
  logic        m_en, m_match, m_ready;

  function automatic logic [15:0] m_reg(input logic [8:0] a);
    case (a)
      9'h100: return {8'h00, m_led};
      9'h140: return {8'h00, m_sw2};
`ifdef MMIO_TIMER_EN
      9'h180: return m_cnt;
      9'h181: return m_cmp;
      9'h182: return {14'b0, m_en, m_match};
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Inputs only change just after a rising edge, so at the falling edge they
  // equal what the next rising edge will sample.
  always @(negedge clk) begin
    logic io_exp, acc, wr;
    logic [15:0] n_cnt;
    logic n_match;
    if (reset) begin
      m_led = '0; m_sw1 = '0; m_sw2 = '0; m_cnt = '0; m_cmp = 16'hFFFF;
      m_rdata = '0; m_en = 1'b0; m_match = 1'b0; m_ready = 1'b0;
    end
    io_exp = (mem_cmd == 2'b01 || mem_cmd == 2'b10) && mem_addr[8];
    check("cyc_ready", mem_ready, m_ready);
    if (m_ready) check("cyc_rdata", read_data, m_rdata);
    check("cyc_led", led_out, m_led);
    check("cyc_irq", irq, m_match);
    check("cyc_iosel", io_sel, io_exp);
    if (!reset) begin
      acc = !m_ready && io_exp;
      wr  = acc && mem_cmd == 2'b10;
      if (acc) m_rdata = (mem_cmd == 2'b01) ? m_reg(mem_addr) : 16'h0000;
`ifdef MMIO_TIMER_EN
      n_cnt   = (wr && mem_addr == 9'h180) ? write_data : m_cnt + {15'b0, m_en};
      n_match = m_match;
      if (wr && mem_addr == 9'h182 && write_data[0]) n_match = 1'b0;
      if (m_en && m_cnt == m_cmp) n_match = 1'b1;
      if (wr && mem_addr == 9'h181) m_cmp = write_data;
      if (wr && mem_addr == 9'h182) m_en = write_data[1];
      m_cnt   = n_cnt;
      m_match = n_match;
`else
      n_cnt = '0; n_match = 1'b0;
`endif
      if (wr && mem_addr == 9'h100) m_led = write_data[7:0];
      m_sw2   = m_sw1;
      m_sw1   = sw_in;
      m_ready = acc;
    end
  end

  // Called just after a rising edge; returns just after a rising edge with the bus idle
  task automatic bus(input logic [1:0] cmd, input logic [8:0] addr,
                     input logic [15:0] wd, output logic [15:0] rd);
    logic ok;
    mem_cmd = cmd; mem_addr = addr; write_data = wd;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin ok = 1'b1; rd = read_data; end
    end
    check("ack_seen", ok, 1'b1);
    @(posedge clk); #1;
    mem_cmd = 2'b00;
  endtask

  initial begin
    logic [15:0] rd;
    logic seen;
    reset = 1'b1; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; sw_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", mem_ready, 1'b0);
    check("rst_rdata", read_data, 16'h0000);
    check("rst_led", led_out, 8'h00);
    check("rst_irq", irq, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    bus(2'b10, 9'h100, 16'h00A5, rd);
    check("led_write", led_out, 8'hA5);
    bus(2'b01, 9'h100, 16'h0000, rd);
    check("led_read", rd, 16'h00A5);

    sw_in = 8'h3C;
    repeat (2) begin @(posedge clk); #1; end
    bus(2'b01, 9'h140, 16'h0000, rd);
    check("sw_read", rd, 16'h003C);
    bus(2'b10, 9'h140, 16'hFFFF, rd);
    bus(2'b01, 9'h140, 16'h0000, rd);
    check("sw_ro", rd, 16'h003C);

    bus(2'b01, 9'h1F0, 16'h0000, rd);
    check("unmapped_read", rd, 16'h0000);

    mem_cmd = 2'b01; mem_addr = 9'h0F0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (mem_ready || io_sel) seen = 1'b1;
    end
    check("ram_ignored", seen, 1'b0);
    mem_cmd = 2'b00;
    @(posedge clk); #1;

`ifdef MMIO_TIMER_EN
    bus(2'b10, 9'h181, 16'h0005, rd);
    bus(2'b01, 9'h181, 16'h0000, rd);
    check("tcmp_read", rd, 16'h0005);
    bus(2'b10, 9'h180, 16'h0000, rd);
    bus(2'b10, 9'h182, 16'h0002, rd);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      seen = irq;
    end
    check("irq_rise", seen, 1'b1);
    bus(2'b10, 9'h182, 16'h0003, rd);
    check("irq_w1c", irq, 1'b0);
    bus(2'b01, 9'h182, 16'h0000, rd);
    check("tstat_en_kept", rd, 16'h0002);

    // Loaded at the accept edge, +1 at the ACK edge, read at the next accept
    bus(2'b10, 9'h180, 16'h0100, rd);
    bus(2'b01, 9'h180, 16'h0000, rd);
    check("tcount_wr_prio", rd, 16'h0101);

    bus(2'b10, 9'h180, 16'hFFFE, rd);
    bus(2'b01, 9'h180, 16'h0000, rd);
    check("tcount_ffff", rd, 16'hFFFF);
    bus(2'b01, 9'h180, 16'h0000, rd);
    check("tcount_wrap", rd, 16'h0001);
`else
    bus(2'b01, 9'h180, 16'h0000, rd);
    check("tmr_absent", rd, 16'h0000);
    bus(2'b10, 9'h182, 16'h0002, rd);
    repeat (10) begin @(posedge clk); #1; end
    check("irq_tied", irq, 1'b0);
`endif

    mem_cmd = 2'b10; mem_addr = 9'h100; write_data = 16'h005A;
    @(posedge clk); #1;
    check("ack_before_rst", mem_ready, 1'b1);
    check("led_before_rst", led_out, 8'h5A);
    #2;
    reset = 1'b1; mem_cmd = 2'b00;
    #1;
    check("rst_mid_ack_ready", mem_ready, 1'b0);
    check("rst_mid_ack_led", led_out, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
